// File: rtl/complex_vector_chunk_streamer_if.sv
// Handshake/bus bundle between the chunk streamer, its two vector memories and the
// dot-product consumer. master = streamer side, slave = environment side.
interface complex_vector_chunk_streamer_if #(
  parameter int ELEMENT_WIDTH = 64,
  parameter int NO_OF_UNITS   = 8,
  parameter int ADDR_WIDTH    = 8
);
  logic                                 start;
  logic                                 busy;
  logic                                 done;
  logic                                 mem_re;
  logic [ADDR_WIDTH-1:0]                mem_addr;
  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_rdata_a;
  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_rdata_b;
  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] chunk_a;
  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] chunk_b;
  logic                                 chunk_valid;
  logic                                 chunk_ready;
  logic                                 chunk_last;

  modport master (
    input  start, mem_rdata_a, mem_rdata_b, chunk_ready,
    output busy, done, mem_re, mem_addr, chunk_a, chunk_b, chunk_valid, chunk_last
  );
  modport slave (
    output start, mem_rdata_a, mem_rdata_b, chunk_ready,
    input  busy, done, mem_re, mem_addr, chunk_a, chunk_b, chunk_valid, chunk_last
  );
endinterface

// File: rtl/complex_vector_chunk_streamer.sv
// Streams NO_OF_UNITS-wide complex chunk pairs from two memories to the dot-product block,
// zero-padding lanes past NOE. Define CHUNK_STREAMER_CONJ_EN to conjugate every chunk_b lane.
module complex_vector_chunk_lane #(
  parameter int ELEMENT_WIDTH = 64
) (
  input  logic [ELEMENT_WIDTH-1:0] a_in,
  input  logic [ELEMENT_WIDTH-1:0] b_in,
  input  logic                     pad,
  output logic [ELEMENT_WIDTH-1:0] a_out,
  output logic [ELEMENT_WIDTH-1:0] b_out
);
  logic [ELEMENT_WIDTH-1:0] b_mod;
`ifdef CHUNK_STREAMER_CONJ_EN
  localparam int HW = ELEMENT_WIDTH / 2;
  // wrapping negate: the most-negative imaginary value maps onto itself
  assign b_mod = {b_in[ELEMENT_WIDTH-1 -: HW], -b_in[HW-1:0]};
`else
  assign b_mod = b_in;
`endif
  assign a_out = pad ? '0 : a_in;
  assign b_out = pad ? '0 : b_mod;
endmodule

module complex_vector_chunk_streamer #(
  parameter int NOE           = 16,
  parameter int ELEMENT_WIDTH = 64,
  parameter int NO_OF_UNITS   = 8,
  parameter int ADDR_WIDTH    = 8
) (
  input logic clk,
  input logic reset,
  complex_vector_chunk_streamer_if.master bus
);
  localparam int NUM_CHUNKS = (NOE + NO_OF_UNITS - 1) / NO_OF_UNITS;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_CHUNKS - 1);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, PRESENT, DONE} state_t;

  state_t                                       state;
  logic [ADDR_WIDTH-1:0]                        chunk_idx;
  logic [NO_OF_UNITS-1:0][ELEMENT_WIDTH-1:0]    rd_a, rd_b, pad_a, pad_b;
  logic [NO_OF_UNITS-1:0]                       lane_pad;

  assign rd_a = bus.mem_rdata_a;
  assign rd_b = bus.mem_rdata_b;

  // element k lives in packed slot U-1-k so element 0 lands in the MS lane
  for (genvar k = 0; k < NO_OF_UNITS; k++) begin : g_lane
    assign lane_pad[k] = (int'(chunk_idx) * NO_OF_UNITS + k) >= NOE;
    complex_vector_chunk_lane #(.ELEMENT_WIDTH(ELEMENT_WIDTH)) u_lane (
      .a_in  (rd_a[NO_OF_UNITS-1-k]),
      .b_in  (rd_b[NO_OF_UNITS-1-k]),
      .pad   (lane_pad[k]),
      .a_out (pad_a[NO_OF_UNITS-1-k]),
      .b_out (pad_b[NO_OF_UNITS-1-k])
    );
  end

  assign bus.mem_re      = (state == READ);
  assign bus.mem_addr    = (state == READ) ? chunk_idx : '0;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.chunk_valid = (state == PRESENT);
  assign bus.chunk_last  = (state == PRESENT) && (chunk_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      chunk_idx   <= '0;
      bus.chunk_a <= '0;
      bus.chunk_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          chunk_idx <= '0;
          if (bus.start) state <= READ;
        end
        READ:    state <= CAPTURE;
        CAPTURE: begin
          bus.chunk_a <= pad_a;
          bus.chunk_b <= pad_b;
          state       <= PRESENT;
        end
        PRESENT: begin
          if (bus.chunk_ready) begin
            if (chunk_idx == LAST_IDX) state <= DONE;
            else begin
              chunk_idx <= chunk_idx + 1'b1;
              state     <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_vector_chunk_streamer.sv
// Scoreboard bench for complex_vector_chunk_streamer: NOE=20, U=8 gives three chunks with a
// padded tail; expected chunks come from a per-element model of the memories.
module tb_complex_vector_chunk_streamer;
  localparam int NOE = 20, W = 64, U = 8, AW = 8;
  localparam int NC = (NOE + U - 1) / U, NE = NC * U, CW = W * U;

  typedef struct {
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  complex_vector_chunk_streamer_if #(.ELEMENT_WIDTH(W), .NO_OF_UNITS(U), .ADDR_WIDTH(AW)) bus();

  complex_vector_chunk_streamer #(.NOE(NOE), .ELEMENT_WIDTH(W), .NO_OF_UNITS(U), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] mem_a [NE];
  logic [W-1:0] mem_b [NE];
  exp_t exp_q [$];
  int   addr_q [$];
  int   checks = 0, failures = 0;
  int   done_seen = 0, exp_done = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // raw memory image of chunk c, element 0 ending up in the MS lane
  function automatic logic [CW-1:0] mem_chunk(input bit sel_b, input int c);
    logic [CW-1:0] r = '0;
    for (int k = 0; k < U; k++)
      r = (r << W) | CW'(sel_b ? mem_b[c*U+k] : mem_a[c*U+k]);
    return r;
  endfunction

  function automatic logic [W-1:0] exp_el(input bit sel_b, input int g);
    logic [W-1:0] e;
    if (g >= NOE) return '0;
    e = sel_b ? mem_b[g] : mem_a[g];
`ifdef CHUNK_STREAMER_CONJ_EN
    if (sel_b) e[W/2-1:0] = 32'(0 - int'(e[W/2-1:0]));
`endif
    return e;
  endfunction

  function automatic logic [CW-1:0] exp_chunk(input bit sel_b, input int c);
    logic [CW-1:0] r = '0;
    for (int k = 0; k < U; k++) r = (r << W) | CW'(exp_el(sel_b, c*U+k));
    return r;
  endfunction

  // memories: one cycle read latency
  always @(posedge clk) begin
    if (bus.mem_re && int'(bus.mem_addr) < NC) begin
      bus.mem_rdata_a <= mem_chunk(1'b0, int'(bus.mem_addr));
      bus.mem_rdata_b <= mem_chunk(1'b1, int'(bus.mem_addr));
    end
  end

  // monitor: address order, hold-under-backpressure, accepted chunk contents, done pulses
  logic          held = 1'b0;
  logic [CW-1:0] held_a, held_b;
  logic          held_last;
  always @(negedge clk) begin
    if (!reset) begin
      if (!bus.mem_re) check("mem_addr_idle", CW'(bus.mem_addr), '0);
      else if (addr_q.size() == 0) check("mem_re_unexpected", 1, 0);
      else check("mem_addr", CW'(bus.mem_addr), CW'(addr_q.pop_front()));
      if (bus.chunk_valid && held) begin
        check("hold_a", bus.chunk_a, held_a);
        check("hold_b", bus.chunk_b, held_b);
        check("hold_last", CW'(bus.chunk_last), CW'(held_last));
      end
      held      = bus.chunk_valid && !bus.chunk_ready;
      held_a    = bus.chunk_a;
      held_b    = bus.chunk_b;
      held_last = bus.chunk_last;
      if (bus.chunk_valid && bus.chunk_ready) begin
        if (exp_q.size() == 0) check("chunk_unexpected", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("chunk_a", bus.chunk_a, e.a);
          check("chunk_b", bus.chunk_b, e.b);
          check("chunk_last", CW'(bus.chunk_last), CW'(e.last));
        end
      end
      if (bus.done) done_seen++;
    end
  end

  task automatic fill_mem(input int fill);
    for (int i = 0; i < NE; i++) begin
      case (fill)
        0: begin mem_a[i] = {32'(i), 32'(i)}; mem_b[i] = {32'(i), 32'(i)}; end
        2: begin mem_a[i] = '1; mem_b[i] = '1; end
        default: begin
          mem_a[i] = {$urandom, $urandom};
          mem_b[i] = {$urandom, $urandom};
          if ($urandom_range(0, 3) == 0) mem_b[i][31:0] = 32'h8000_0000;
        end
      endcase
    end
  endtask

  // mode 0: ready high; 1: random ready plus stray start pulses; 2: 5-cycle stall on chunk 0
  task automatic run_stream(input int fill, input int mode, input bit abort);
    int cyc, done_cyc, first_valid, bp_left;
    fill_mem(fill);
    for (int c = 0; c < NC; c++) begin
      exp_t e;
      e.a = exp_chunk(1'b0, c);
      e.b = exp_chunk(1'b1, c);
      e.last = (c == NC - 1);
      exp_q.push_back(e);
      addr_q.push_back(c);
    end
    bus.chunk_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; done_cyc = 0; first_valid = 0; bp_left = 5;
    if (mode == 0) check("mem_re_latency", CW'(bus.mem_re), 1);
    while (done_cyc == 0 && cyc < 200) begin
      if (bus.chunk_valid && first_valid == 0) first_valid = cyc;
      if (abort && bus.chunk_valid) begin
        reset = 1'b1;
        bus.chunk_ready = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", CW'(bus.busy), 0);
        check("abort_valid", CW'(bus.chunk_valid), 0);
        check("abort_done", CW'(bus.done), 0);
        check("abort_chunk_a", bus.chunk_a, '0);
        return;
      end
      if (bus.done) done_cyc = cyc;
      else begin
        if (mode == 1) begin
          bus.chunk_ready = 1'($urandom_range(0, 1));
          bus.start = bus.busy && ($urandom_range(0, 2) == 0);
        end else if (mode == 2) begin
          if (bus.chunk_valid && bp_left > 0) begin
            bus.chunk_ready = 1'b0;
            bp_left--;
          end else bus.chunk_ready = 1'b1;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
    bus.chunk_ready = 1'b1;
    if (done_cyc == 0) check("done_timeout", 1, 0);
    else exp_done++;
    if (mode == 0) begin
      check("first_valid_cycle", CW'(first_valid), 3);
      check("done_cycle", CW'(done_cyc), CW'(3*NC + 1));
    end
    @(posedge clk); #1;
    check("idle_after_done", CW'(bus.busy), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.chunk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", CW'(bus.busy), 0);
    check("rst_done", CW'(bus.done), 0);
    check("rst_mem_re", CW'(bus.mem_re), 0);
    check("rst_mem_addr", CW'(bus.mem_addr), 0);
    check("rst_valid", CW'(bus.chunk_valid), 0);
    check("rst_last", CW'(bus.chunk_last), 0);
    check("rst_chunk_a", bus.chunk_a, '0);
    check("rst_chunk_b", bus.chunk_b, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    run_stream(0, 0, 1'b0);
    run_stream(2, 0, 1'b0);
    run_stream(1, 2, 1'b0);
    run_stream(1, 0, 1'b1);
    run_stream(1, 0, 1'b0);
    for (int i = 0; i < 8; i++) run_stream(1, 1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("done_count", CW'(done_seen), CW'(exp_done));
    check("exp_q_empty", CW'(exp_q.size()), 0);
    check("addr_q_empty", CW'(addr_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
